mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 29 ++
 rtl/lsu_load_align.sv | 37 +++
 rtl/mem_lsu.sv | 149 ++++++++++++++
 tb/tb_mem_lsu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and widths for the load/store unit: FSM states, load funct3 codes, bus widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_lsu_pkg;

  localparam int XLEN         = 32;
  localparam int BE_W         = XLEN / 8;
  localparam int REG_AW       = 5;
  localparam int HOLD_W       = 5;
  localparam int HOLD_MEM_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 shares the low codes with loads (sb/sh/sw = 000/001/010).
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword/word out of a bus read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by low address bits, then extend by load type.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage LSU: issues loads/stores on a req/gnt/rvalid data bus, extracts load data, writes back.
// Latency: store completes on grant; load completes on rvalid; idle writeback is a 0-cycle pass-through.
// Backpressure: hold_req_o stalls the pipe until complete; hold_en_i[3] parks the result in DONE.
// Optional: MEM_LSU_MISALIGN_CHK_EN flags misaligned lh/lhu/sh/lw/sw with err_o and skips the bus.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   inst_i,
  input  logic              cs_i,
  input  logic              mem_we_i,
  input  logic [BE_W-1:0]   mem_wem_i,
  input  logic [XLEN-1:0]   mem_din,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic              regs_wen_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [HOLD_W-1:0] hold_en_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [BE_W-1:0]   dbus_be_o,
  output logic [XLEN-1:0]   dbus_addr_o,
  output logic [XLEN-1:0]   dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [XLEN-1:0]   dbus_rdata_i,
  output logic              regs_wen_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              hold_req_o,
  output logic              err_o
);

  localparam int             CW       = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TMO_CYC - 1);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] done_data_q, done_data_d;
  logic            done_err_q, done_err_d;

  logic [2:0]      funct3;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            misalign, issue, accept, in_bus, ok_done, tmo, complete, err, hold_mem;
  logic            unused_bits;

  assign funct3      = inst_i[14:12];
  assign hold_mem    = hold_en_i[HOLD_MEM_BIT];
  assign unused_bits = ^{inst_i[31:15], inst_i[11:0], hold_en_i[4], hold_en_i[2:0]};

  lsu_load_align u_align (
    .funct3_i (funct3),
    .addr_lo_i(mem_addr_i[1:0]),
    .rdata_i  (dbus_rdata_i),
    .data_o   (load_data)
  );

  // Alignment check only matters on the first (IDLE) cycle of an access.
  always_comb begin
`ifdef MEM_LSU_MISALIGN_CHK_EN
    misalign = cs_i && (state_q == IDLE) &&
               (((mem_we_i ? (funct3 == F3_SH) : (funct3 == F3_LH || funct3 == F3_LHU)) && mem_addr_i[0]) ||
                ((funct3 == F3_LW) && (mem_addr_i[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
  end

  // Bus handshake, completion/timeout decode and next-state.
  always_comb begin
    issue    = cs_i && !misalign && (state_q == IDLE || state_q == REQ);
    accept   = issue && dbus_gnt_i;
    in_bus   = (state_q == REQ) || (state_q == WAIT);
    // A normal finish (store grant or load rvalid) wins over a timeout in the same cycle.
    ok_done  = (accept && mem_we_i) || ((state_q == WAIT) && dbus_rvalid_i);
    tmo      = in_bus && (cnt_q == TMO_LAST) && !ok_done;
    complete = ok_done || tmo || misalign;
    err      = tmo || misalign;
    wb_data  = mem_we_i ? rd_data_i : load_data;

    state_d     = state_q;
    done_data_d = done_data_q;
    done_err_d  = done_err_q;
    if (state_q == DONE) begin
      if (!hold_mem) state_d = IDLE;
    end else if (complete) begin
      if (hold_mem) begin
        state_d     = DONE;
        done_data_d = wb_data;
        done_err_d  = err;
      end else begin
        state_d = IDLE;
      end
    end else if (accept) begin
      state_d = WAIT;
    end else if (issue) begin
      state_d = REQ;
    end

    // Counter tracks bus-wait cycles; it restarts whenever the access leaves REQ/WAIT.
    if (in_bus && (state_d == REQ || state_d == WAIT)) cnt_d = cnt_q + CW'(1);
    else                                                  cnt_d = '0;
  end

  // Output drive; reset forces all handshake outputs low.
  always_comb begin
    dbus_req_o   = issue && !rst;
    dbus_we_o    = mem_we_i;
    dbus_be_o    = mem_we_i ? mem_wem_i : {BE_W{1'b1}};
    dbus_addr_o  = {mem_addr_i[XLEN-1:2], 2'b00};
    dbus_wdata_o = mem_din;
    hold_req_o   = !rst && cs_i && !complete && (state_q != DONE);
    err_o        = !rst && err;
    rd_addr_o    = rd_addr_i;

    regs_wen_o = 1'b0;
    rd_data_o  = wb_data;
    if (state_q == DONE) begin
      regs_wen_o = regs_wen_i && !done_err_q;
      rd_data_o  = done_data_q;
    end else if (state_q == IDLE && !cs_i) begin
      regs_wen_o = regs_wen_i;
      rd_data_o  = rd_data_i;
    end else if (complete) begin
      regs_wen_o = regs_wen_i && !err;
    end
    if (rst) regs_wen_o = 1'b0;
  end

  // State, timeout counter and parked DONE result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_data_q <= '0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_data_q <= done_data_d;
      done_err_q  <= done_err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus random transactions checked against a transaction-level model.
// Latency: model predicts the completion cycle of each access from grant/rvalid delays and timeout.
// Backpressure: hold_en_i[3] randomly parks results in DONE for 0..2 cycles.
module tb_mem_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        cs_i, mem_we_i;
  logic [3:0]  mem_wem_i;
  logic [31:0] mem_din, mem_addr_i;
  logic        regs_wen_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [4:0]  hold_en_i;
  logic        dbus_req_o, dbus_we_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        regs_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        hold_req_o, err_o;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  mem_lsu #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .cs_i(cs_i), .mem_we_i(mem_we_i),
    .mem_wem_i(mem_wem_i), .mem_din(mem_din), .mem_addr_i(mem_addr_i),
    .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .hold_en_i(hold_en_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_be_o(dbus_be_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .hold_req_o(hold_req_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extraction: shift the word down to the addressed lane, then mask and extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic bit ref_misalign(input bit we, input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_LSU_MISALIGN_CHK_EN
    bit half;
    half = we ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
    return (half && a[0]) || (f3 == 3'b010 && a != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One idle cycle: writeback must pass straight through; stray bus responses are ignored.
  task automatic idle_cycle(input bit force_rv);
    @(posedge clk); #1;
    cs_i          = 1'b0;
    regs_wen_i    = 1'($urandom_range(0, 1));
    rd_addr_i     = 5'($urandom);
    rd_data_i     = $urandom;
    hold_en_i     = 5'($urandom);
    dbus_gnt_i    = 1'($urandom_range(0, 1));
    dbus_rvalid_i = force_rv ? 1'b1 : 1'($urandom_range(0, 1));
    dbus_rdata_i  = $urandom;
    @(negedge clk);
    chk("idle_wen",   32'(regs_wen_o), 32'(regs_wen_i));
    chk("idle_rdata", rd_data_o, rd_data_i);
    chk("idle_raddr", 32'(rd_addr_o), 32'(rd_addr_i));
    chk("idle_hold",  32'(hold_req_o), 32'd0);
    chk("idle_req",   32'(dbus_req_o), 32'd0);
    chk("idle_err",   32'(err_o), 32'd0);
  endtask

  // One access. g = cycles before grant, r = empty WAIT cycles before rvalid, h = DONE hold cycles.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [3:0] be,
                         input int g, input int r, input int h);
    int          c;
    bit          terr, mis, wen;
    logic [4:0]  rda;
    logic [31:0] rdd, wb, ins;
    mis = ref_misalign(we, f3, addr[1:0]);
    wen = 1'($urandom_range(0, 1));
    rda = 5'($urandom);
    rdd = $urandom;
    if (mis)                            begin c = 0;         terr = 1'b1; end
    else if (we && g <= TMO)            begin c = g;         terr = 1'b0; end
    else if (!we && g + 1 + r <= TMO)   begin c = g + 1 + r; terr = 1'b0; end
    else                                begin c = TMO;       terr = 1'b1; end
    wb = we ? rdd : ref_load(f3, addr[1:0], rdata);

    for (int k = 0; k <= c + h; k++) begin
      @(posedge clk); #1;
      ins           = $urandom;
      ins[14:12]    = f3;
      inst_i        = ins;
      cs_i          = 1'b1;
      mem_we_i      = we;
      mem_wem_i     = be;
      mem_din       = wdata;
      mem_addr_i    = addr;
      regs_wen_i    = wen;
      rd_addr_i     = rda;
      rd_data_i     = rdd;
      hold_en_i     = 5'($urandom);
      hold_en_i[3]  = (k < c) ? 1'($urandom_range(0, 1)) : (k < c + h);
      dbus_gnt_i    = (k == g);
      dbus_rvalid_i = (k == g + 1 + r && k <= c) ? 1'b1 :
                      (k <= g || k > c) ? 1'($urandom_range(0, 1)) : 1'b0;
      dbus_rdata_i  = (k == g + 1 + r && k <= c) ? rdata : $urandom;
      @(negedge clk);
      chk("req", 32'(dbus_req_o), 32'(k <= c && k <= g && !mis));
      if (k <= c && k <= g && !mis) begin
        chk("bus_addr",  dbus_addr_o, {addr[31:2], 2'b00});
        chk("bus_we",    32'(dbus_we_o), 32'(we));
        chk("bus_be",    32'(dbus_be_o), we ? 32'(be) : 32'hF);
        chk("bus_wdata", dbus_wdata_o, wdata);
      end
      chk("hold", 32'(hold_req_o), 32'(k < c));
      chk("err",  32'(err_o), 32'(k == c && terr));
      chk("wen",  32'(regs_wen_o), 32'(k >= c && !terr && wen));
      if (k >= c) begin
        chk("raddr", 32'(rd_addr_o), 32'(rda));
        if (!terr) chk("rdata", rd_data_o, wb);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          we;
    logic [2:0]  f3;
    int          g;
    n_checks = 0;
    n_errors = 0;

    rst = 1'b1; cs_i = 1'b1; mem_we_i = 1'b0; inst_i = 32'h0000_2003; mem_wem_i = 4'hF;
    mem_din = 32'h0; mem_addr_i = 32'h100; regs_wen_i = 1'b1; rd_addr_i = 5'd3;
    rd_data_i = 32'h0; hold_en_i = 5'h0; dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1;
    dbus_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req",  32'(dbus_req_o), 32'd0);
    chk("rst_hold", 32'(hold_req_o), 32'd0);
    chk("rst_wen",  32'(regs_wen_o), 32'd0);
    chk("rst_err",  32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cs_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    idle_cycle(1'b0);

    // Directed scenarios.
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'h0, 0, 2, 0);
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 4'h0, 0, 0, 0);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 4'h0, 1, 0, 0);
    run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 4'h0, 0, 1, 0);
    run_txn(1'b1, 3'b010, 32'h200, 32'h12345678, 32'h0, 4'hF, 3, 0, 0);
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 4'h0, 0, 0, 2);
    idle_cycle(1'b0);
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 4'h0, 99, 0, 0);
    run_txn(1'b1, 3'b010, 32'h404, 32'hAAAA5555, 32'h0, 4'hF, 99, 0, 1);
    run_txn(1'b0, 3'b001, 32'h500, 32'h0, 32'h1234F00D, 4'h0, 1, 2, 0);
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h01020304, 4'h0, 0, 0, 0);
    idle_cycle(1'b0);

    // Reset during WAIT abandons the load; a late rvalid afterwards is ignored.
    @(posedge clk); #1;
    cs_i = 1'b1; mem_we_i = 1'b0; inst_i = 32'h0000_2003; mem_addr_i = 32'h40;
    dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("abort_req", 32'(dbus_req_o), 32'd1);
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    @(negedge clk);
    chk("abort_wait_hold", 32'(hold_req_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_rst_hold", 32'(hold_req_o), 32'd0);
    chk("abort_rst_req",  32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cs_i = 1'b0;
    idle_cycle(1'b1);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      run_txn(we, f3, $urandom, $urandom, $urandom, 4'($urandom), g,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) idle_cycle(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
